// File: rtl/dp_pkg.sv
// Shared constants for the dot-product layer scheduler and the DotProductSt engine.
package dp_pkg;

    localparam int DEF_PIXEL_N     = 10;
    localparam int DEF_WEIGHT_SIZE = 19;
    localparam int DEF_VAL_SIZE    = 26;
    localparam int DEF_PARALLEL    = 1;
    localparam int FPM_DELAY       = 5;
    localparam int FPA_DELAY       = 3;
    localparam int DEF_DP_LATENCY  = DEF_PIXEL_N / DEF_PARALLEL + FPM_DELAY + FPA_DELAY + 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        OUT   = ST_OUT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/dp_wait_counter.sv
// Loadable down-counter that times the engine's compute window; zero flags the last cycle.
module dp_wait_counter
    import dp_pkg::*;
#(
    parameter int CNT_W = $clog2(DEF_DP_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dp_layer_scheduler.sv
// Walks one dot-product engine over every neuron of a layer: fetch weights, load, run, emit result.
module dp_layer_scheduler
    import dp_pkg::*;
#(
    parameter int PIXEL_N     = DEF_PIXEL_N,
    parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
    parameter int VAL_SIZE    = DEF_VAL_SIZE,
    parameter int NEUR_W      = 8,
    parameter int DP_LATENCY  = DEF_DP_LATENCY
) (
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic                           start,
    input  logic [NEUR_W-1:0]              num_neurons,
    output logic                           busy,
    output logic                           w_rd_en,
    output logic [NEUR_W-1:0]              w_addr,
    input  logic [PIXEL_N*WEIGHT_SIZE-1:0] w_data,
    output logic                           dp_rst,
    output logic [PIXEL_N*WEIGHT_SIZE-1:0] dp_weights,
    input  logic [VAL_SIZE-1:0]            dp_value,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [VAL_SIZE-1:0]            res_data,
    output logic [NEUR_W-1:0]              res_index,
    output logic                           done
);

    localparam int               CNT_W    = $clog2(DP_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DP_LATENCY - 1);
    localparam logic [NEUR_W-1:0] IDX_ONE = NEUR_W'(1);

    state_t            state, state_n;
    logic [NEUR_W-1:0] n_reg, index, index_n;
    logic              latch_n, cnt_load, cnt_dec, cnt_zero;

    dp_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .load        (cnt_load),
        .load_val    (CNT_INIT),
        .dec         (cnt_dec),
        .zero        (cnt_zero)
    );

    always_comb begin
        state_n  = state;
        index_n  = index;
        latch_n  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_neurons != '0) begin
                        state_n = FETCH;
                        index_n = '0;
                        latch_n = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                cnt_load = 1'b1;
                state_n  = RUN;
            end
            RUN: begin
                if (cnt_zero) state_n = OUT;
                else          cnt_dec = 1'b1;
            end
            OUT: begin
                // res_valid is always high in OUT, so res_ready alone completes the handshake.
                if (res_ready) begin
                    if (index == n_reg - IDX_ONE) begin
                        state_n = DONE;
                    end else begin
                        index_n = index + IDX_ONE;
                        state_n = FETCH;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state      <= IDLE;
            index      <= '0;
            n_reg      <= '0;
            busy       <= 1'b0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            dp_rst     <= 1'b1;
            dp_weights <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_index  <= '0;
            done       <= 1'b0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            busy      <= (state_n != IDLE);
            w_rd_en   <= (state_n == FETCH);
            w_addr    <= index_n;
            dp_rst    <= (state_n != RUN);
            res_valid <= (state_n == OUT);
            done      <= (state_n == DONE);
            if (latch_n) n_reg <= num_neurons;
            if (state == LOAD) dp_weights <= w_data;
            if ((state == RUN) && cnt_zero) begin
                res_data  <= dp_value;
                res_index <= index;
            end
        end
    end

endmodule

// File: tb/tb_dp_layer_scheduler.sv
// Directed/randomized bench for dp_layer_scheduler with a weight RAM and engine model.
module tb_dp_layer_scheduler;

    localparam int PIXEL_N     = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int VAL_SIZE    = 26;
    localparam int NEUR_W      = 8;
    localparam int DP_LATENCY  = 21;
    localparam int PERIOD      = DP_LATENCY + 3;
    localparam int WW          = PIXEL_N * WEIGHT_SIZE;

    logic              clk = 1'b0;
    logic              GlobalReset;
    logic              start;
    logic [NEUR_W-1:0] num_neurons;
    logic              busy, w_rd_en, dp_rst, res_valid, res_ready, done;
    logic [NEUR_W-1:0] w_addr, res_index;
    logic [WW-1:0]     w_data, dp_weights;
    logic [VAL_SIZE-1:0] dp_value, res_data;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] wmem [256];
    int unsigned   pix [PIXEL_N];
    int            eng_k = 0;
    int            acc_cnt = 0;
    logic          mon_en = 1'b0;
    logic          rst_at_edge = 1'b0;
    logic          rd_h1 = 1'b0, rd_h2 = 1'b0;
    logic [WW-1:0] prev_w;

    dp_layer_scheduler dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .start       (start),
        .num_neurons (num_neurons),
        .busy        (busy),
        .w_rd_en     (w_rd_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .dp_rst      (dp_rst),
        .dp_weights  (dp_weights),
        .dp_value    (dp_value),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_index   (res_index),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [VAL_SIZE-1:0] dot(input logic [WW-1:0] w);
        longint acc = 0;
        for (int k = 0; k < PIXEL_N; k++)
            acc += longint'(w[k*WEIGHT_SIZE +: WEIGHT_SIZE]) * longint'(pix[k]);
        return VAL_SIZE'(acc);
    endfunction

    always @(posedge clk) begin
        if (w_rd_en) w_data <= wmem[w_addr];
        eng_k       <= dp_rst ? 0 : eng_k + 1;
        rst_at_edge <= GlobalReset;
        if (GlobalReset && res_valid && res_ready) acc_cnt <= acc_cnt + 1;
    end

    // Engine output is garbage until it has run for its full latency.
    always_comb begin
        if (!dp_rst && eng_k >= DP_LATENCY - 1) dp_value = dot(dp_weights);
        else                                    dp_value = ~dot(dp_weights);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_at_edge && dp_weights !== prev_w) begin
                checks++;
                assert (rd_h2) else begin
                    errors++;
                    $error("FAIL wchg_outside_load observed=%0b expected=1", rd_h2);
                end
            end
            checks++;
            assert (dp_rst || (busy && !w_rd_en && !res_valid && !done)) else begin
                errors++;
                $error("FAIL dp_rst_low_outside_run observed=%0b expected=1", dp_rst);
            end
        end
        rd_h2  = rd_h1;
        rd_h1  = w_rd_en;
        prev_w = dp_weights;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_data();
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < PIXEL_N; k++)
                wmem[i][k*WEIGHT_SIZE +: WEIGHT_SIZE] = WEIGHT_SIZE'($urandom);
        for (int k = 0; k < PIXEL_N; k++) pix[k] = $urandom_range(0, 255);
    endtask

    // Expected outputs in cycle c of an n-neuron layer started at cycle 0 with res_ready held high.
    task automatic check_sched(input int c, input int n, input string tag);
        int i = 0, p = 0;
        logic e_busy = 1'b0, e_rd = 1'b0, e_run = 1'b0, e_out = 1'b0, e_done = 1'b0;
        if (c >= 1 && c <= n * PERIOD) begin
            i = (c - 1) / PERIOD;
            p = (c - 1) % PERIOD;
            e_busy = 1'b1;
            e_rd   = (p == 0);
            e_run  = (p >= 2 && p <= PERIOD - 2);
            e_out  = (p == PERIOD - 1);
        end else if (c == n * PERIOD + 1) begin
            e_busy = 1'b1;
            e_done = 1'b1;
        end
        chk({tag, "_busy"}, 64'(busy), 64'(e_busy));
        chk({tag, "_rd_en"}, 64'(w_rd_en), 64'(e_rd));
        chk({tag, "_dp_rst"}, 64'(dp_rst), 64'(!e_run));
        chk({tag, "_valid"}, 64'(res_valid), 64'(e_out));
        chk({tag, "_done"}, 64'(done), 64'(e_done));
        if (e_rd) chk({tag, "_addr"}, 64'(w_addr), 64'(i));
        if (e_out) begin
            chk({tag, "_index"}, 64'(res_index), 64'(i));
            chk({tag, "_data"}, 64'(res_data), 64'(dot(wmem[i])));
        end
    endtask

    task automatic run_layer(input int n, input int poke_c, input string tag);
        int a0 = acc_cnt;
        start = 1'b1;
        num_neurons = NEUR_W'(n);
        cyc();
        start = 1'b0;
        for (int c = 1; c <= n * PERIOD + 3; c++) begin
            check_sched(c, n, tag);
            if (c == poke_c) begin
                start = 1'b1;
                num_neurons = NEUR_W'(n + 3);
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        chk({tag, "_results"}, 64'(acc_cnt - a0), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b;
        logic [VAL_SIZE-1:0] d0;
        GlobalReset = 1'b0;
        start = 1'b0;
        num_neurons = '0;
        res_ready = 1'b1;
        new_data();
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rd_en", 64'(w_rd_en), 0);
        chk("rst_valid", 64'(res_valid), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_dp_rst", 64'(dp_rst), 1);
        chk("rst_addr", 64'(w_addr), 0);
        chk("rst_weights", 64'(dp_weights == '0), 1);
        chk("rst_data", 64'(res_data), 0);
        chk("rst_index", 64'(res_index), 0);
        GlobalReset = 1'b1;
        cyc();
        mon_en = 1'b1;

        run_layer(3, -1, "basic");

        new_data();
        run_layer(int'($urandom_range(1, 4)), -1, "rand");

        // Backpressure on the first result of a 2-neuron layer.
        new_data();
        a0 = acc_cnt;
        res_ready = 1'b0;
        start = 1'b1;
        num_neurons = 8'd2;
        cyc();
        start = 1'b0;
        b = 0;
        while (!res_valid && b < 100) begin cyc(); b++; end
        chk("bp_first_valid", 64'(res_valid), 1);
        chk("bp_first_index", 64'(res_index), 0);
        chk("bp_first_data", 64'(res_data), 64'(dot(wmem[0])));
        d0 = res_data;
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold_valid", 64'(res_valid), 1);
            chk("bp_hold_data", 64'(res_data), 64'(d0));
            chk("bp_hold_index", 64'(res_index), 0);
            cyc();
        end
        res_ready = 1'b1;
        chk("bp_still_valid", 64'(res_valid), 1);
        cyc();
        chk("bp_next_fetch", 64'(w_rd_en), 1);
        chk("bp_next_addr", 64'(w_addr), 1);
        chk("bp_valid_drop", 64'(res_valid), 0);
        b = 0;
        while (!res_valid && b < 100) begin cyc(); b++; end
        chk("bp_second_valid", 64'(res_valid), 1);
        chk("bp_second_index", 64'(res_index), 1);
        chk("bp_second_data", 64'(res_data), 64'(dot(wmem[1])));
        cyc();
        chk("bp_done", 64'(done), 1);
        cyc();
        chk("bp_idle", 64'(busy), 0);
        chk("bp_results", 64'(acc_cnt - a0), 2);

        // Zero-neuron layer.
        start = 1'b1;
        num_neurons = '0;
        cyc();
        start = 1'b0;
        chk("zero_done", 64'(done), 1);
        chk("zero_busy", 64'(busy), 1);
        chk("zero_rd_en", 64'(w_rd_en), 0);
        chk("zero_valid", 64'(res_valid), 0);
        chk("zero_dp_rst", 64'(dp_rst), 1);
        cyc();
        chk("zero_done_end", 64'(done), 0);
        chk("zero_idle", 64'(busy), 0);
        chk("zero_rd_en2", 64'(w_rd_en), 0);

        // Start pulsed during RUN of neuron 0 must be ignored.
        new_data();
        run_layer(2, 10, "ign");

        // Reset during RUN of neuron 1, then a clean restart.
        new_data();
        a0 = acc_cnt;
        start = 1'b1;
        num_neurons = 8'd3;
        cyc();
        start = 1'b0;
        for (int c = 1; c < PERIOD + 10; c++) begin
            check_sched(c, 3, "mid");
            cyc();
        end
        GlobalReset = 1'b0;
        cyc();
        GlobalReset = 1'b1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_dp_rst", 64'(dp_rst), 1);
        chk("mid_rst_valid", 64'(res_valid), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_addr", 64'(w_addr), 0);
        chk("mid_rst_index", 64'(res_index), 0);
        chk("mid_rst_data", 64'(res_data), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("mid_post_done", 64'(done), 0);
            chk("mid_post_busy", 64'(busy), 0);
        end
        chk("mid_results", 64'(acc_cnt - a0), 1);
        run_layer(2, -1, "restart");

        // Largest layer.
        new_data();
        run_layer(255, -1, "max");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
